uart_tx: RTL

//  8N1 UART transmitter; the companion to the team's uart_rx, sharing its baud parameters.

---
 rtl/uart_tx.sv | 103 ++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a one-byte holding register for back-to-back frames.
// Ports:
//   sys_clk   - system clock (single domain)
//   sys_rst_n - asynchronous active-low reset
//   pi_data   - byte to send, sampled when pi_flag=1
//   pi_flag   - one-cycle write strobe
//   tx        - serial line, idles high, LSB first
//   tx_ready  - holding register empty; a strobe this cycle is accepted
//   tx_busy   - a frame is being shifted
//   ovf       - one-cycle pulse when a strobe was dropped
module uart_tx #(
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       tx,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       ovf
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int CW = $clog2(BAUD_CNT_MAX + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT_MAX - 1);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
    logic [1:0] state_q, state_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, hold_q, hold_d;
    logic ready_q, ready_d, tx_q, tx_d, busy_q, busy_d, ovf_q, ovf_d;
    logic bit_end, load_point, take_hold, take_in;
    always_comb begin
        bit_end    = baud_cnt_q == BAUD_LAST;
        // A new frame may begin from IDLE or on the last stop clock (no idle gap).
        load_point = state_q == IDLE || (state_q == STOP && bit_end);
        take_hold  = load_point && !ready_q;
        take_in    = load_point && ready_q && pi_flag;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        ready_d    = ready_q;
        ovf_d      = pi_flag && !ready_q;
        baud_cnt_d = (state_q == IDLE || bit_end) ? '0 : baud_cnt_q + 1'b1;
        case (state_q)
            START: if (bit_end) begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: if (bit_end) begin
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + 3'd1;
                state_d   = bit_cnt_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (bit_end) state_d = IDLE;
            default: ;
        endcase
        // A queued byte has priority; a strobe in that same cycle sees ready_q=0 and is dropped.
        if (take_hold) begin
            shift_d = hold_q;
            ready_d = 1'b1;
            state_d = START;
        end else if (take_in) begin
            shift_d = pi_data;
            state_d = START;
        end else if (pi_flag && ready_q) begin
            hold_d  = pi_data;
            ready_d = 1'b0;
        end
        // Line level is registered from the next state so tx and tx_busy change together.
        tx_d   = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            ready_q    <= 1'b1;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            ready_q    <= ready_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end
    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign ovf      = ovf_q;
endmodule
